traffic_light_monitor: RTL

- Observer/checker on the far end of the traffic-light lamp interface; consumes R, G, Y and pass exactly as the controller sees them.
- Locks onto the lamp sequence, mirrors the controller's 3072-cycle period position, and reports the current phase.
- Flags illegal lamp patterns and timing deviations; sits beside the controller in system benches and in the FPGA top for on-board self-check.

---
 rtl/traffic_light_monitor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive observer of the traffic-light lamp interface. Locks onto the lamp
//   sequence on an R->G transition, mirrors the controller's 3072-cycle period
//   position, and flags multi-lamp patterns and lamps that disagree with the
//   expected pattern for the mirrored position.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   R, G, Y      lamp inputs
//   pass         pedestrian pass request (as seen by the controller)
//   locked       monitor synchronised to the lamp sequence
//   phase        0=G0 1=OFF1 2=G1 3=OFF2 4=G2 5=Y 6=R 7=HUNT
//   pos          mirrored period position 0..3071 (0 while hunting)
//   err          one-cycle error pulse
//   err_code     1 multi-lamp, 2 wrong lamp; held until the next err
//   err_count    saturating count of err pulses
//   period_done  one-cycle pulse on natural wrap 3071->0
//   restart      one-cycle pulse on a legal pass restart
module traffic_light_monitor #(
    parameter int LOSS_THRESH = 4,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                R,
    input  logic                G,
    input  logic                Y,
    input  logic                pass,
    output logic                locked,
    output logic [2:0]          phase,
    output logic [11:0]         pos,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                period_done,
    output logic                restart
);

    // Lamp encoding {R,G,Y}
    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_G   = 3'b010;
    localparam logic [2:0] L_Y   = 3'b001;

    localparam logic [11:0] POS_LAST = 12'd3071;
    localparam logic [3:0]  MIS_LAST = 4'(LOSS_THRESH - 1);

    typedef enum logic {S_HUNT, S_LOCK} state_t;

    function automatic logic [2:0] expected_lamp(input logic [11:0] p);
        if      (p < 12'd1024) return L_G;
        else if (p < 12'd1152) return L_OFF;
        else if (p < 12'd1280) return L_G;
        else if (p < 12'd1408) return L_OFF;
        else if (p < 12'd1536) return L_G;
        else if (p < 12'd2048) return L_Y;
        else                   return L_R;
    endfunction

    logic [2:0]          lamp_in;
    logic [2:0]          lamp_q, lamp_d;
    logic                pass_q, pass_d;
    state_t              state_q, state_d;
    logic [11:0]         pos_q, pos_d;
    logic [3:0]          mis_q, mis_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                period_done_q, period_done_d;
    logic                restart_q, restart_d;
    logic                multi_lamp, wrong_lamp;

    assign lamp_in = {R, G, Y};

    assign multi_lamp = (lamp_q[2] & lamp_q[1]) | (lamp_q[2] & lamp_q[0]) |
                        (lamp_q[1] & lamp_q[0]);
    assign wrong_lamp = (state_q == S_LOCK) && (lamp_q != expected_lamp(pos_q));

    always_comb begin
        lamp_d        = lamp_in;
        pass_d        = pass;
        state_d       = state_q;
        pos_d         = pos_q;
        mis_d         = mis_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        err_count_d   = err_count_q;
        period_done_d = 1'b0;
        restart_d     = 1'b0;

        // Multi-lamp wins over wrong lamp.
        if (multi_lamp) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
        end else if (wrong_lamp) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
        end

        if (err_d && (err_count_q != {ERRCNT_W{1'b1}}))
            err_count_d = err_count_q + ERRCNT_W'(1);

        case (state_q)
            S_HUNT: begin
                pos_d = 12'd0;
                mis_d = 4'd0;
                // R in the held sample and G in the sample being captured:
                // the G sample lands in lamp_q together with pos=0, so pos_q
                // always describes the lamp_q it is checked against.
                if (lamp_q == L_R && lamp_in == L_G)
                    state_d = S_LOCK;
            end
            default: begin
                if (err_d && mis_q == MIS_LAST) begin
                    state_d = S_HUNT;
                    pos_d   = 12'd0;
                    mis_d   = 4'd0;
                end else begin
                    mis_d = err_d ? mis_q + 4'd1 : 4'd0;
                    // Restart outranks the natural wrap.
                    if (pass_q && pos_q > 12'd1023) begin
                        pos_d     = 12'd0;
                        restart_d = 1'b1;
                    end else if (pos_q == POS_LAST) begin
                        pos_d         = 12'd0;
                        period_done_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 12'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_q        <= L_OFF;
            pass_q        <= 1'b0;
            state_q       <= S_HUNT;
            pos_q         <= 12'd0;
            mis_q         <= 4'd0;
            err_q         <= 1'b0;
            err_code_q    <= 2'd0;
            err_count_q   <= '0;
            period_done_q <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            lamp_q        <= lamp_d;
            pass_q        <= pass_d;
            state_q       <= state_d;
            pos_q         <= pos_d;
            mis_q         <= mis_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
            period_done_q <= period_done_d;
            restart_q     <= restart_d;
        end
    end

    always_comb begin
        phase = 3'd7;
        if (state_q == S_LOCK) begin
            if      (pos_q < 12'd1024) phase = 3'd0;
            else if (pos_q < 12'd1152) phase = 3'd1;
            else if (pos_q < 12'd1280) phase = 3'd2;
            else if (pos_q < 12'd1408) phase = 3'd3;
            else if (pos_q < 12'd1536) phase = 3'd4;
            else if (pos_q < 12'd2048) phase = 3'd5;
            else                       phase = 3'd6;
        end
    end

    assign locked      = (state_q == S_LOCK);
    assign pos         = pos_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign err_count   = err_count_q;
    assign period_done = period_done_q;
    assign restart     = restart_q;

endmodule
